// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C master driver: FSM states, quarter
// phases, the R/W encoding and how many quarters each bus phase lasts.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_MNACK,
    ST_STOP
  } state_t;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int START_QUARTERS = 4;
  localparam int BIT_QUARTERS   = 4;
  localparam int STOP_QUARTERS  = 4;
  localparam int BYTE_BITS      = 8;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period timebase: divides clk by CLK_DIV into quarter ticks and
// freezes while the slave stretches SCL.
module i2c_bit_timer
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     hold,
  input  logic     clear,
  output logic     tick,
  output quarter_t quarter
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // tick marks the last clk cycle of a quarter; it never fires during a stretch
  assign tick = en && !hold && (div_cnt == DIV_LAST);

  // NOTE: sequential state uses <= so every register reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      quarter <= Q0;
    end else if (!en) begin
      div_cnt <= '0;
      quarter <= Q0;
    end else if (tick) begin
      div_cnt <= '0;
      quarter <= clear ? Q0 : quarter + 2'd1;
    end else if (!hold) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_driver.sv
// Single-byte I2C master: START, address+R/W, one data byte written or read,
// STOP. Open-drain scl/sda are only ever pulled low or released.
module i2c_master_driver
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [6:0] i_chip_addr,
  input  logic       i_rw,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_rdata_valid,
  output logic       o_ack_err,
  inout  wire        scl,
  inout  wire        sda
);

  state_t     state_q, state_d;
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] wdata_q;
  logic [7:0] rx_q;
  logic [2:0] bit_cnt;
  logic       sda_sample;
  logic       scl_low, sda_low;
  logic       tick, hold, phase_end, sample_now, last_bit, accept, state_change;
  quarter_t   quarter, last_q;
  logic [7:0] addr_byte;
  logic [2:0] bit_idx;

  // Bus inputs are read raw: a synchronizer would delay stretch detection and
  // skew the fixed quarter timing.
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign o_busy       = (state_q != ST_IDLE);
  assign accept       = (state_q == ST_IDLE) && i_start && !o_done;
  assign addr_byte    = {addr_q, rw_q};
  assign bit_idx      = 3'd7 - bit_cnt;
  assign last_bit     = (bit_cnt == 3'(BYTE_BITS - 1));
  assign last_q       = (state_q == ST_START) ? quarter_t'(START_QUARTERS - 1) :
                        (state_q == ST_STOP)  ? quarter_t'(STOP_QUARTERS - 1)  :
                                                quarter_t'(BIT_QUARTERS - 1);
  assign phase_end    = tick && (quarter == last_q);
  assign sample_now   = tick && (quarter == Q2);
  assign hold         = !scl_low && (scl == 1'b0);
  assign state_change = (state_d != state_q);

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (o_busy),
    .hold    (hold),
    .clear   (state_change),
    .tick    (tick),
    .quarter (quarter)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    unique case (state_q)
      ST_START: begin
        scl_low = (quarter == Q3);
        sda_low = (quarter == Q2) || (quarter == Q3);
      end
      ST_ADDR: begin
        scl_low = (quarter == Q0) || (quarter == Q1);
        sda_low = !addr_byte[bit_idx];
      end
      ST_WDATA: begin
        scl_low = (quarter == Q0) || (quarter == Q1);
        sda_low = !wdata_q[bit_idx];
      end
      ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_MNACK:
        scl_low = (quarter == Q0) || (quarter == Q1);
      ST_STOP: begin
        scl_low = (quarter == Q0);
        sda_low = (quarter != Q3);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept) state_d = ST_START;
      ST_START:     if (phase_end) state_d = ST_ADDR;
      ST_ADDR:      if (phase_end && last_bit) state_d = ST_ADDR_ACK;
      ST_ADDR_ACK:  if (phase_end)
                      state_d = sda_sample ? ST_STOP :
                                (rw_q == RW_READ) ? ST_RDATA : ST_WDATA;
      ST_WDATA:     if (phase_end && last_bit) state_d = ST_WDATA_ACK;
      ST_WDATA_ACK: if (phase_end) state_d = ST_STOP;
      ST_RDATA:     if (phase_end && last_bit) state_d = ST_MNACK;
      ST_MNACK:     if (phase_end) state_d = ST_STOP;
      ST_STOP:      if (phase_end) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      rw_q          <= RW_WRITE;
      wdata_q       <= '0;
      rx_q          <= '0;
      bit_cnt       <= '0;
      sda_sample    <= 1'b1;
      o_done        <= 1'b0;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_ack_err     <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      o_rdata_valid <= 1'b0;
      if (accept) begin
        addr_q    <= i_chip_addr;
        rw_q      <= i_rw;
        wdata_q   <= i_wdata;
        o_ack_err <= 1'b0;
      end
      if (state_change)   bit_cnt <= '0;
      else if (phase_end) bit_cnt <= bit_cnt + 3'd1;
      if (sample_now) begin
        sda_sample <= sda;
        if (state_q == ST_RDATA) rx_q <= {rx_q[6:0], sda};
      end
      if (phase_end && sda_sample &&
          (state_q == ST_ADDR_ACK || state_q == ST_WDATA_ACK))
        o_ack_err <= 1'b1;
      // completion lands in the cycle after STOP's last quarter
      if (state_q == ST_STOP && phase_end) begin
        o_done <= 1'b1;
        if (rw_q == RW_READ && !o_ack_err) begin
          o_rdata       <= rx_q;
          o_rdata_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_driver.sv
// Directed bench for i2c_master_driver: a bus-level slave model at address
// 7'h50, a vector table of whole transfers, and hand sequences for corner cases.
module tb_i2c_master_driver;

  localparam int          CLK_DIV    = 4;
  localparam logic [6:0]  SLAVE_ADDR = 7'h50;
  localparam int          MAX_CYC    = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [6:0] i_chip_addr = '0;
  logic       i_rw = 1'b0;
  logic [7:0] i_wdata = '0;
  logic       o_busy, o_done, o_rdata_valid, o_ack_err;
  logic [7:0] o_rdata;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  logic slv_scl_low = 1'b0;
  logic slv_sda_low = 1'b0;
  assign scl = slv_scl_low ? 1'b0 : 1'bz;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_chip_addr   (i_chip_addr),
    .i_rw          (i_rw),
    .i_wdata       (i_wdata),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_ack_err     (o_ack_err),
    .scl           (scl),
    .sda           (sda)
  );

  // Slave model, sampled on the falling clk edge, away from DUT updates.
  logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_now, sda_now;
  logic       in_xfer = 1'b0, slv_rw = 1'b0, addr_acked = 1'b0;
  logic       stretch_en = 1'b0;
  logic [7:0] shreg = '0, slave_rdata = '0;
  logic [7:0] rx_bytes [2];
  logic       ack_bits [2];
  int         bitpos = 0, byte_idx = 0, start_cnt = 0, stop_cnt = 0, stretch_left = 0;

  always @(negedge clk) begin
    scl_now = (scl !== 1'b0);
    sda_now = (sda !== 1'b0);
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) slv_scl_low = 1'b0;
    end
    if (prev_scl && scl_now && prev_sda && !sda_now) begin
      in_xfer = 1'b1; bitpos = 0; byte_idx = 0; addr_acked = 1'b0;
      rx_bytes[0] = '0; rx_bytes[1] = '0; ack_bits[0] = 1'b1; ack_bits[1] = 1'b1;
      start_cnt++;
    end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
      in_xfer = 1'b0; slv_sda_low = 1'b0;
      stop_cnt++;
    end else if (in_xfer && !prev_scl && scl_now) begin
      if (bitpos < 8) begin
        shreg = {shreg[6:0], sda_now};
        bitpos++;
      end else begin
        if (byte_idx < 2) begin
          rx_bytes[byte_idx] = shreg;
          ack_bits[byte_idx] = sda_now;
        end
        byte_idx++;
        bitpos = 0;
      end
    end else if (in_xfer && prev_scl && !scl_now) begin
      slv_sda_low = 1'b0;
      if (bitpos == 8) begin
        if (byte_idx == 0) begin
          slv_rw      = shreg[0];
          addr_acked  = (shreg[7:1] == SLAVE_ADDR);
          slv_sda_low = addr_acked;
        end else if (byte_idx == 1 && !slv_rw) begin
          slv_sda_low = 1'b1;
        end
      end else if (byte_idx == 1 && slv_rw && addr_acked) begin
        slv_sda_low = !slave_rdata[7 - bitpos];
      end
      if (stretch_en && byte_idx == 1 && !slv_rw && addr_acked && bitpos == 3) begin
        slv_scl_low  = 1'b1;
        stretch_left = 30;
        stretch_en   = 1'b0;
      end
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse i_start, then sample #1 after each edge until o_done; the accepting
  // edge counts as cycle 1.
  task automatic run_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          output int cycles, output int valid_cnt, output logic valid_at_done,
                          output logic busy_at_done, output logic ack_at_done,
                          output logic [7:0] rdata_at_done);
    logic done_seen;
    @(negedge clk);
    i_rw = rw; i_chip_addr = addr; i_wdata = wdata; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    cycles = 1; valid_cnt = 0; done_seen = 1'b0;
    valid_at_done = 1'b0; busy_at_done = 1'b1; ack_at_done = 1'b0; rdata_at_done = '0;
    check("busy_after_accept", o_busy, 1'b1);
    check("ack_err_cleared_on_accept", o_ack_err, 1'b0);
    while (!done_seen && cycles < MAX_CYC) begin
      if (o_rdata_valid) valid_cnt++;
      if (o_done) begin
        done_seen     = 1'b1;
        valid_at_done = o_rdata_valid;
        busy_at_done  = o_busy;
        ack_at_done   = o_ack_err;
        rdata_at_done = o_rdata;
      end else begin
        @(posedge clk);
        #1 cycles++;
      end
    end
    check("done_within_bound", done_seen, 1'b1);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] srd;
    int         exp_cycles;
    logic       exp_ack_err;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic [7:0] exp_b0;
    logic       exp_a0;
    int         nbytes;
    logic [7:0] exp_b1;
    logic       exp_a1;
  } vec_t;

  vec_t       vecs [6];
  int         cyc, vcnt, s0, p0;
  logic       v_done, b_done, a_done;
  logic [7:0] r_done;

  initial begin
    vecs[0] = '{1'b0, 7'h50, 8'hA5, 8'h00, 321, 1'b0, 1'b0, 8'h00, 8'hA0, 1'b0, 2, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 7'h50, 8'h00, 8'h3C, 321, 1'b0, 1'b1, 8'h3C, 8'hA1, 1'b0, 2, 8'h3C, 1'b1};
    vecs[2] = '{1'b0, 7'h12, 8'h77, 8'h00, 177, 1'b1, 1'b0, 8'h00, 8'h24, 1'b1, 1, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 7'h50, 8'h00, 8'h00, 321, 1'b0, 1'b0, 8'h00, 8'hA0, 1'b0, 2, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 7'h50, 8'h00, 8'hFF, 321, 1'b0, 1'b1, 8'hFF, 8'hA1, 1'b0, 2, 8'hFF, 1'b1};
    vecs[5] = '{1'b1, 7'h7F, 8'h00, 8'h55, 177, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1, 8'h00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_rdata", o_rdata, 8'h00);
    check("rst_rdata_valid", o_rdata_valid, 1'b0);
    check("rst_ack_err", o_ack_err, 1'b0);
    check("rst_scl_released", scl, 1'b1);
    check("rst_sda_released", sda, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("idle_busy_after_release", o_busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      slave_rdata = vecs[i].srd;
      s0 = start_cnt; p0 = stop_cnt;
      run_xfer(vecs[i].rw, vecs[i].addr, vecs[i].wdata, cyc, vcnt, v_done, b_done, a_done, r_done);
      check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cycles);
      check($sformatf("v%0d_busy_at_done", i), b_done, 1'b0);
      check($sformatf("v%0d_ack_err", i), a_done, vecs[i].exp_ack_err);
      check($sformatf("v%0d_valid_with_done", i), v_done, vecs[i].exp_valid);
      check($sformatf("v%0d_valid_pulses", i), vcnt, 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("v%0d_rdata", i), r_done, vecs[i].exp_rdata);
      repeat (10) @(posedge clk);
      #1 check($sformatf("v%0d_ack_err_held", i), o_ack_err, vecs[i].exp_ack_err);
      check($sformatf("v%0d_start_count", i), start_cnt - s0, 1);
      check($sformatf("v%0d_stop_count", i), stop_cnt - p0, 1);
      check($sformatf("v%0d_bus_byte0", i), rx_bytes[0], vecs[i].exp_b0);
      check($sformatf("v%0d_bus_ack0", i), ack_bits[0], vecs[i].exp_a0);
      if (vecs[i].nbytes == 2) begin
        check($sformatf("v%0d_bus_byte1", i), rx_bytes[1], vecs[i].exp_b1);
        check($sformatf("v%0d_bus_ack1", i), ack_bits[1], vecs[i].exp_a1);
      end
    end

    // Slave stretches SCL during WDATA bit 3.
    stretch_en = 1'b1;
    run_xfer(1'b0, 7'h50, 8'h5A, cyc, vcnt, v_done, b_done, a_done, r_done);
    check("stretch_happened", stretch_en, 1'b0);
    check("stretch_delay_min", (cyc >= 341), 1'b1);
    check("stretch_delay_max", (cyc <= 380), 1'b1);
    check("stretch_ack_err", a_done, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("stretch_bus_byte1", rx_bytes[1], 8'h5A);

    // Reset asserted during WDATA bit 4 (Q1: SCL low, data bit 0 drives SDA low).
    @(negedge clk);
    i_rw = 1'b0; i_chip_addr = 7'h50; i_wdata = 8'hA5; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc = 1;
    while (cyc < 230) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("pre_reset_scl_low", scl, 1'b0);
    check("pre_reset_sda_low", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_scl_released", scl, 1'b1);
    check("reset_sda_released", sda, 1'b1);
    check("reset_busy", o_busy, 1'b0);
    check("reset_rdata_cleared", o_rdata, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_xfer(1'b0, 7'h50, 8'hC3, cyc, vcnt, v_done, b_done, a_done, r_done);
    check("post_reset_done_cycle", cyc, 321);
    check("post_reset_ack_err", a_done, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_bus_byte0", rx_bytes[0], 8'hA0);
    check("post_reset_bus_byte1", rx_bytes[1], 8'hC3);

    // i_start while busy and in the o_done cycle must both be ignored.
    s0 = start_cnt;
    @(negedge clk);
    i_rw = 1'b0; i_chip_addr = 7'h50; i_wdata = 8'h81; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc = 1;
    while (!o_done && cyc < MAX_CYC) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == 60) begin
        i_start = 1'b1; i_chip_addr = 7'h12; i_wdata = 8'h18;
      end
      if (cyc == 61) i_start = 1'b0;
    end
    check("ignore_done_cycle", cyc, 321);
    i_start = 1'b1; i_chip_addr = 7'h50; i_wdata = 8'h18;
    @(posedge clk);
    #1 i_start = 1'b0;
    check("ignore_start_in_done_cycle", o_busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("ignore_still_idle", o_busy, 1'b0);
    check("ignore_single_start", start_cnt - s0, 1);
    check("ignore_wdata_unchanged", rx_bytes[1], 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
